// File: rtl/riscv_apu_wb_buf.sv
// APU writeback buffer: writes returning APU results into the register file
// write port, or queues them in arrival order while ALU/LSU own the port.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   apu_valid_i / apu_ready_o     incoming APU result handshake
//   apu_result_i, apu_flags_i     result data and flags
//   apu_waddr_i                   destination register
//   wb_block_i                    RF port owned by ALU/LSU this cycle
//   rf_we_o, rf_waddr_o,
//   rf_wdata_o, flags_we_o,
//   flags_o                       register-file / flag write port
//   read_regs_i, read_regs_valid_i,
//   write_regs_i, write_regs_valid_i
//                                 decode operands checked for hazards
//   read_dep_o, write_dep_o       hazard against a buffered entry
//   pending_o, count_o            buffer non-empty / occupancy
//   overflow_o                    sticky: result arrived while full
module riscv_apu_wb_buf #(
    parameter int DEPTH       = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int FLAGS_WIDTH = 5,
    parameter int ADDR_WIDTH  = 6,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,

    input  logic                       apu_valid_i,
    output logic                       apu_ready_o,
    input  logic [DATA_WIDTH-1:0]      apu_result_i,
    input  logic [FLAGS_WIDTH-1:0]     apu_flags_i,
    input  logic [ADDR_WIDTH-1:0]      apu_waddr_i,

    input  logic                       wb_block_i,
    output logic                       rf_we_o,
    output logic [ADDR_WIDTH-1:0]      rf_waddr_o,
    output logic [DATA_WIDTH-1:0]      rf_wdata_o,
    output logic                       flags_we_o,
    output logic [FLAGS_WIDTH-1:0]     flags_o,

    input  logic [2:0][ADDR_WIDTH-1:0] read_regs_i,
    input  logic [2:0]                 read_regs_valid_i,
    input  logic [1:0][ADDR_WIDTH-1:0] write_regs_i,
    input  logic [1:0]                 write_regs_valid_i,
    output logic                       read_dep_o,
    output logic                       write_dep_o,

    output logic                       pending_o,
    output logic [CNT_W-1:0]           count_o,
    output logic                       overflow_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0]  addr_q  [DEPTH];
    logic [DATA_WIDTH-1:0]  data_q  [DEPTH];
    logic [FLAGS_WIDTH-1:0] flags_q [DEPTH];
    logic [DEPTH-1:0]       valid_q;

    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    logic empty;
    logic accept;
    logic write_through;
    logic push;
    logic pop;

    assign empty         = (count_q == '0);
    assign apu_ready_o   = !rst_i && (count_q < FULL_CNT);
    assign accept        = apu_valid_i && apu_ready_o;
    // Bypass only when nothing is queued ahead, otherwise order would break.
    assign write_through = accept && empty && !wb_block_i;
    assign push          = accept && !write_through;
    assign pop           = !rst_i && !empty && !wb_block_i;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (apu_valid_i && !apu_ready_o)
                overflow_q <= 1'b1;
            if (pop) begin
                rd_ptr_q          <= ptr_inc(rd_ptr_q);
                valid_q[rd_ptr_q] <= 1'b0;
            end
            // Pop and push never target the same slot: push needs count<DEPTH.
            if (push) begin
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
                valid_q[wr_ptr_q] <= 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked in valid_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[wr_ptr_q]  <= apu_waddr_i;
            data_q[wr_ptr_q]  <= apu_result_i;
            flags_q[wr_ptr_q] <= apu_flags_i;
        end
    end

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        flags_o    = '0;
        if (pop) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = addr_q[rd_ptr_q];
            rf_wdata_o = data_q[rd_ptr_q];
            flags_o    = flags_q[rd_ptr_q];
        end else if (write_through) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = apu_waddr_i;
            rf_wdata_o = apu_result_i;
            flags_o    = apu_flags_i;
        end
    end

    assign flags_we_o = rf_we_o;

    // Stored entries only; the head being drained still counts.
    always_comb begin
        read_dep_o  = 1'b0;
        write_dep_o = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            for (int i = 0; i < 3; i++) begin
                if (valid_q[e] && read_regs_valid_i[i] &&
                    read_regs_i[i] == addr_q[e])
                    read_dep_o = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                if (valid_q[e] && write_regs_valid_i[i] &&
                    write_regs_i[i] == addr_q[e])
                    write_dep_o = 1'b1;
            end
        end
        if (rst_i) begin
            read_dep_o  = 1'b0;
            write_dep_o = 1'b0;
        end
    end

    assign count_o    = rst_i ? '0 : count_q;
    assign pending_o  = !rst_i && (count_q != '0);
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_riscv_apu_wb_buf.sv
// Self-checking bench for riscv_apu_wb_buf: directed scenarios followed by
// randomized traffic against a queue-based reference model.
module tb_riscv_apu_wb_buf;

    localparam int DEPTH = 2;
    localparam int DW    = 32;
    localparam int FW    = 5;
    localparam int AW    = 6;
    localparam int CW    = $clog2(DEPTH + 1);

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               apu_valid_i;
    logic               apu_ready_o;
    logic [DW-1:0]      apu_result_i;
    logic [FW-1:0]      apu_flags_i;
    logic [AW-1:0]      apu_waddr_i;
    logic               wb_block_i;
    logic               rf_we_o;
    logic [AW-1:0]      rf_waddr_o;
    logic [DW-1:0]      rf_wdata_o;
    logic               flags_we_o;
    logic [FW-1:0]      flags_o;
    logic [2:0][AW-1:0] read_regs_i;
    logic [2:0]         read_regs_valid_i;
    logic [1:0][AW-1:0] write_regs_i;
    logic [1:0]         write_regs_valid_i;
    logic               read_dep_o;
    logic               write_dep_o;
    logic               pending_o;
    logic [CW-1:0]      count_o;
    logic               overflow_o;

    int checks   = 0;
    int failures = 0;

    riscv_apu_wb_buf #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .FLAGS_WIDTH(FW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .apu_valid_i       (apu_valid_i),
        .apu_ready_o       (apu_ready_o),
        .apu_result_i      (apu_result_i),
        .apu_flags_i       (apu_flags_i),
        .apu_waddr_i       (apu_waddr_i),
        .wb_block_i        (wb_block_i),
        .rf_we_o           (rf_we_o),
        .rf_waddr_o        (rf_waddr_o),
        .rf_wdata_o        (rf_wdata_o),
        .flags_we_o        (flags_we_o),
        .flags_o           (flags_o),
        .read_regs_i       (read_regs_i),
        .read_regs_valid_i (read_regs_valid_i),
        .write_regs_i      (write_regs_i),
        .write_regs_valid_i(write_regs_valid_i),
        .read_dep_o        (read_dep_o),
        .write_dep_o       (write_dep_o),
        .pending_o         (pending_o),
        .count_o           (count_o),
        .overflow_o        (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [FW-1:0] f;
    } ent_t;

    // Inputs change 1 time unit after the rising edge; outputs are
    // observed 1 unit later, well away from the next edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        rst_i              = 1'b0;
        apu_valid_i        = 1'b0;
        apu_result_i       = '0;
        apu_flags_i        = '0;
        apu_waddr_i        = '0;
        wb_block_i         = 1'b0;
        read_regs_i        = '0;
        read_regs_valid_i  = '0;
        write_regs_i       = '0;
        write_regs_valid_i = '0;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [FW-1:0] f);
        apu_valid_i  = 1'b1;
        apu_waddr_i  = a;
        apu_result_i = d;
        apu_flags_i  = f;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        send(6'h01, 32'h1234, 5'h1);
        tick();
        #1;
        checks++;
        if (apu_ready_o !== 1'b0 || rf_we_o !== 1'b0 || flags_we_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outs ready=%b we=%b fwe=%b want 0 0 0",
                     apu_ready_o, rf_we_o, flags_we_o);
        end
        checks++;
        if (count_o !== '0 || pending_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_count count=%0d pending=%b want 0 0",
                     count_o, pending_o);
        end
        idle_inputs();
        tick();
        checks++;
        if (overflow_o !== 1'b0 || apu_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_after ovf=%b ready=%b want 0 1",
                     overflow_o, apu_ready_o);
        end
    endtask

    task automatic test_write_through();
        do_reset();
        send(6'h05, 32'hDEADBEEF, 5'h1a);
        #1;
        checks++;
        if (rf_we_o !== 1'b1 || flags_we_o !== 1'b1 || rf_waddr_o !== 6'h05 ||
            rf_wdata_o !== 32'hDEADBEEF || flags_o !== 5'h1a) begin
            failures++;
            $display("FAIL wt_write we=%b fwe=%b a=%h d=%h f=%h want 1 1 05 deadbeef 1a",
                     rf_we_o, flags_we_o, rf_waddr_o, rf_wdata_o, flags_o);
        end
        checks++;
        if (read_dep_o !== 1'b0) begin
            failures++;
            $display("FAIL wt_nodep dep=%b want 0", read_dep_o);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (count_o !== '0 || rf_we_o !== 1'b0 || rf_waddr_o !== '0 ||
            rf_wdata_o !== '0 || flags_o !== '0) begin
            failures++;
            $display("FAIL wt_after count=%0d we=%b a=%h d=%h f=%h want 0 0 0 0 0",
                     count_o, rf_we_o, rf_waddr_o, rf_wdata_o, flags_o);
        end
    endtask

    task automatic test_block_drain();
        do_reset();
        wb_block_i = 1'b1;
        send(6'h01, 32'hAAAA0001, 5'h01);
        tick();
        send(6'h02, 32'hBBBB0002, 5'h02);
        tick();
        apu_valid_i = 1'b0;
        tick();
        checks++;
        if (count_o !== 2 || apu_ready_o !== 1'b0 || pending_o !== 1'b1 ||
            rf_we_o !== 1'b0) begin
            failures++;
            $display("FAIL blk_full count=%0d ready=%b pend=%b we=%b want 2 0 1 0",
                     count_o, apu_ready_o, pending_o, rf_we_o);
        end
        wb_block_i = 1'b0;
        #1;
        checks++;
        if (rf_we_o !== 1'b1 || rf_waddr_o !== 6'h01 ||
            rf_wdata_o !== 32'hAAAA0001 || flags_o !== 5'h01) begin
            failures++;
            $display("FAIL blk_drain1 we=%b a=%h d=%h f=%h want 1 01 aaaa0001 01",
                     rf_we_o, rf_waddr_o, rf_wdata_o, flags_o);
        end
        tick();
        checks++;
        if (count_o !== 1 || rf_we_o !== 1'b1 || rf_waddr_o !== 6'h02 ||
            rf_wdata_o !== 32'hBBBB0002) begin
            failures++;
            $display("FAIL blk_drain2 count=%0d we=%b a=%h d=%h want 1 1 02 bbbb0002",
                     count_o, rf_we_o, rf_waddr_o, rf_wdata_o);
        end
        tick();
        checks++;
        if (count_o !== 0 || rf_we_o !== 1'b0 || pending_o !== 1'b0) begin
            failures++;
            $display("FAIL blk_empty count=%0d we=%b pend=%b want 0 0 0",
                     count_o, rf_we_o, pending_o);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        wb_block_i = 1'b1;
        send(6'h03, 32'h33, 5'h3);
        tick();
        send(6'h04, 32'h44, 5'h4);
        tick();
        send(6'h09, 32'h99, 5'h9);
        #1;
        checks++;
        if (apu_ready_o !== 1'b0 || overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL ovf_pre ready=%b ovf=%b want 0 0", apu_ready_o, overflow_o);
        end
        tick();
        apu_valid_i = 1'b0;
        checks++;
        if (overflow_o !== 1'b1 || count_o !== 2) begin
            failures++;
            $display("FAIL ovf_set ovf=%b count=%0d want 1 2", overflow_o, count_o);
        end
        wb_block_i = 1'b0;
        #1;
        checks++;
        if (rf_waddr_o !== 6'h03 || rf_wdata_o !== 32'h33) begin
            failures++;
            $display("FAIL ovf_head a=%h d=%h want 03 33", rf_waddr_o, rf_wdata_o);
        end
        tick();
        checks++;
        if (rf_waddr_o !== 6'h04 || rf_wdata_o !== 32'h44) begin
            failures++;
            $display("FAIL ovf_second a=%h d=%h want 04 44", rf_waddr_o, rf_wdata_o);
        end
        tick();
        tick();
        checks++;
        if (overflow_o !== 1'b1 || count_o !== 0 || rf_we_o !== 1'b0) begin
            failures++;
            $display("FAIL ovf_sticky ovf=%b count=%0d we=%b want 1 0 0",
                     overflow_o, count_o, rf_we_o);
        end
        do_reset();
        checks++;
        if (overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear ovf=%b want 0", overflow_o);
        end
    endtask

    task automatic test_hazards();
        do_reset();
        wb_block_i = 1'b1;
        send(6'h07, 32'h77, 5'h7);
        tick();
        apu_valid_i       = 1'b0;
        read_regs_i[0]    = 6'h01;
        read_regs_i[1]    = 6'h02;
        read_regs_i[2]    = 6'h07;
        read_regs_valid_i = 3'b100;
        #1;
        checks++;
        if (read_dep_o !== 1'b1 || write_dep_o !== 1'b0) begin
            failures++;
            $display("FAIL hz_read rdep=%b wdep=%b want 1 0", read_dep_o, write_dep_o);
        end
        read_regs_valid_i = 3'b011;
        #1;
        checks++;
        if (read_dep_o !== 1'b0) begin
            failures++;
            $display("FAIL hz_read_inv rdep=%b want 0", read_dep_o);
        end
        write_regs_i[0]    = 6'h07;
        write_regs_i[1]    = 6'h08;
        write_regs_valid_i = 2'b01;
        #1;
        checks++;
        if (write_dep_o !== 1'b1) begin
            failures++;
            $display("FAIL hz_write wdep=%b want 1", write_dep_o);
        end
        // Head being drained still counts as a dependency.
        wb_block_i = 1'b0;
        #1;
        checks++;
        if (write_dep_o !== 1'b1 || rf_we_o !== 1'b1) begin
            failures++;
            $display("FAIL hz_drain wdep=%b we=%b want 1 1", write_dep_o, rf_we_o);
        end
        tick();
        checks++;
        if (write_dep_o !== 1'b0) begin
            failures++;
            $display("FAIL hz_gone wdep=%b want 0", write_dep_o);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        wb_block_i = 1'b1;
        send(6'h0a, 32'h1010, 5'h0a);
        tick();
        wb_block_i = 1'b0;
        send(6'h0b, 32'h1111, 5'h0b);
        #1;
        checks++;
        if (rf_we_o !== 1'b1 || rf_waddr_o !== 6'h0a || apu_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL pp_head we=%b a=%h ready=%b want 1 0a 1",
                     rf_we_o, rf_waddr_o, apu_ready_o);
        end
        tick();
        apu_valid_i = 1'b0;
        #1;
        checks++;
        if (count_o !== 1 || rf_waddr_o !== 6'h0b || rf_wdata_o !== 32'h1111) begin
            failures++;
            $display("FAIL pp_next count=%0d a=%h d=%h want 1 0b 1111",
                     count_o, rf_waddr_o, rf_wdata_o);
        end
        tick();
        checks++;
        if (count_o !== 0) begin
            failures++;
            $display("FAIL pp_empty count=%0d want 0", count_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wb_block_i = 1'b1;
        send(6'h11, 32'h11, 5'h1);
        tick();
        send(6'h12, 32'h12, 5'h2);
        tick();
        send(6'h13, 32'h13, 5'h3);
        tick();
        idle_inputs();
        rst_i = 1'b1;
        #1;
        checks++;
        if (rf_we_o !== 1'b0 || count_o !== 0 || pending_o !== 1'b0) begin
            failures++;
            $display("FAIL rm_during we=%b count=%0d pend=%b want 0 0 0",
                     rf_we_o, count_o, pending_o);
        end
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (rf_we_o !== 1'b0 || count_o !== 0 || pending_o !== 1'b0 ||
                overflow_o !== 1'b0) begin
                failures++;
                $display("FAIL rm_after%0d we=%b count=%0d pend=%b ovf=%b want 0 0 0 0",
                         i, rf_we_o, count_o, pending_o, overflow_o);
            end
            tick();
        end
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t in;
        bit   m_ovf;
        bit   v, blk, rst, ready, we, rdep, wdep;
        ent_t out;
        do_reset();
        m_ovf = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst  = ($urandom_range(0, 49) == 0);
            v    = ($urandom_range(0, 9) < 6);
            blk  = ($urandom_range(0, 1) == 1);
            in.a = AW'($urandom_range(0, 7));
            in.d = $urandom;
            in.f = FW'($urandom);
            rst_i        = rst;
            apu_valid_i  = v;
            wb_block_i   = blk;
            apu_waddr_i  = in.a;
            apu_result_i = in.d;
            apu_flags_i  = in.f;
            for (int i = 0; i < 3; i++)
                read_regs_i[i] = AW'($urandom_range(0, 7));
            for (int i = 0; i < 2; i++)
                write_regs_i[i] = AW'($urandom_range(0, 7));
            read_regs_valid_i  = 3'($urandom);
            write_regs_valid_i = 2'($urandom);

            ready = !rst && (q.size() < DEPTH);
            we    = 1'b0;
            out   = '0;
            rdep  = 1'b0;
            wdep  = 1'b0;
            if (!rst) begin
                if (q.size() > 0 && !blk) begin
                    we  = 1'b1;
                    out = q[0];
                end else if (v && ready && !blk) begin
                    we  = 1'b1;
                    out = in;
                end
                foreach (q[k]) begin
                    for (int i = 0; i < 3; i++)
                        if (read_regs_valid_i[i] && read_regs_i[i] == q[k].a)
                            rdep = 1'b1;
                    for (int i = 0; i < 2; i++)
                        if (write_regs_valid_i[i] && write_regs_i[i] == q[k].a)
                            wdep = 1'b1;
                end
            end
            #1;
            checks++;
            if (apu_ready_o !== ready || rf_we_o !== we || flags_we_o !== we) begin
                failures++;
                $display("FAIL rnd_ctl cyc=%0d ready=%b we=%b fwe=%b want %b %b %b",
                         cyc, apu_ready_o, rf_we_o, flags_we_o, ready, we, we);
            end
            checks++;
            if (rf_waddr_o !== out.a || rf_wdata_o !== out.d || flags_o !== out.f) begin
                failures++;
                $display("FAIL rnd_data cyc=%0d a=%h d=%h f=%h want %h %h %h",
                         cyc, rf_waddr_o, rf_wdata_o, flags_o, out.a, out.d, out.f);
            end
            checks++;
            if (read_dep_o !== rdep || write_dep_o !== wdep) begin
                failures++;
                $display("FAIL rnd_dep cyc=%0d rdep=%b wdep=%b want %b %b",
                         cyc, read_dep_o, write_dep_o, rdep, wdep);
            end
            checks++;
            if (count_o !== CW'(rst ? 0 : q.size()) ||
                pending_o !== (!rst && q.size() != 0) || overflow_o !== m_ovf) begin
                failures++;
                $display("FAIL rnd_state cyc=%0d count=%0d pend=%b ovf=%b want %0d %b %b",
                         cyc, count_o, pending_o, overflow_o,
                         rst ? 0 : q.size(), !rst && q.size() != 0, m_ovf);
            end

            if (rst) begin
                q.delete();
                m_ovf = 1'b0;
            end else begin
                if (v && !ready)
                    m_ovf = 1'b1;
                if (q.size() > 0 && !blk) begin
                    void'(q.pop_front());
                    if (v && ready)
                        q.push_back(in);
                end else if (v && ready && blk) begin
                    q.push_back(in);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_through();
        test_block_drain();
        test_overflow();
        test_hazards();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
